// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier arbiter.
package mult_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      DELIVER = 2'd3
   } arb_state_t;

   localparam int unsigned NREQ_DEF    = 4;
   localparam int unsigned WIDTH_DEF   = 16;
   localparam int unsigned TIMEOUT_DEF = 64;

   // Ceiling log2; used to size the pointer and the timeout counter.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
   import mult_arb_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF,
   parameter int unsigned PW   = clog2(NREQ_DEF)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic            valid_o,
   output logic [PW-1:0]   idx_o
);

   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;
   logic [PW:0]       sum;
   logic              found;

   // Rotating the doubled vector puts ptr at bit 0, so the first set bit wins.
   always_comb begin
      dbl     = {req_i, req_i};
      rot     = NREQ'(dbl >> ptr_i);
      valid_o = |req_i;
      idx_o   = '0;
      sum     = '0;
      found   = 1'b0;
      for (int unsigned j = 0; j < NREQ; j++) begin
         if (!found && rot[j]) begin
            found = 1'b1;
            sum   = {1'b0, ptr_i} + (PW+1)'(j);
            if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
            idx_o = sum[PW-1:0];
         end
      end
   end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one start/finish multiplier among NREQ requesters.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int unsigned NREQ    = NREQ_DEF,
   parameter int unsigned WIDTH   = WIDTH_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic                  clk,
   input  logic                  nRST,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_in1,
   input  logic [NREQ*WIDTH-1:0] req_in2,
   output logic [NREQ-1:0]       done,
   output logic                  err,
   output logic [WIDTH-1:0]      result,
   output logic                  busy,
   output logic [WIDTH-1:0]      mult_in1,
   output logic [WIDTH-1:0]      mult_in2,
   output logic                  start_mult,
   input  logic [WIDTH-1:0]      mult_out,
   input  logic                  mult_finish
);

   localparam int unsigned PW = clog2(NREQ);
   localparam int unsigned CW = clog2(TIMEOUT);

   arb_state_t       state_q, state_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    grant_q, grant_d;
   logic [WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             err_q, err_d;
   logic [NREQ-1:0]  done_q, done_d;
   logic             start_q, start_d;
   logic             busy_q, busy_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             pick_valid;
   logic [PW-1:0]    pick_idx;
   logic [WIDTH-1:0] sel1, sel2;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   always_comb begin
      sel1 = '0;
      sel2 = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (pick_idx == PW'(i)) begin
            sel1 = req_in1[i*WIDTH +: WIDTH];
            sel2 = req_in2[i*WIDTH +: WIDTH];
         end
      end
   end

   // Strobe outputs are registered from the next state so they line up with it.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      in1_d    = in1_q;
      in2_d    = in2_q;
      result_d = result_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      done_d   = '0;
      start_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d = pick_idx;
               in1_d   = sel1;
               in2_d   = sel2;
               start_d = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (mult_finish) begin
               result_d = mult_out;
               err_d    = 1'b0;
               done_d   = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
               state_d  = DELIVER;
            end else if (cnt_q == CW'(TIMEOUT-1)) begin
               result_d = '0;
               err_d    = 1'b1;
               done_d   = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
               state_d  = DELIVER;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DELIVER: begin
            ptr_d   = (grant_q == PW'(NREQ-1)) ? '0 : grant_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         grant_q  <= '0;
         in1_q    <= '0;
         in2_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         done_q   <= '0;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         in1_q    <= in1_d;
         in2_q    <= in2_d;
         result_q <= result_d;
         err_q    <= err_d;
         done_q   <= done_d;
         start_q  <= start_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
      end
   end

   assign done       = done_q;
   assign err        = err_q;
   assign result     = result_q;
   assign busy       = busy_q;
   assign mult_in1   = in1_q;
   assign mult_in2   = in2_q;
   assign start_mult = start_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a behavioural start/finish multiplier.
module tb_mult_arbiter;

   localparam int unsigned NREQ    = 4;
   localparam int unsigned WIDTH   = 16;
   localparam int unsigned TIMEOUT = 16;

   typedef struct {
      int unsigned      idx;
      logic [WIDTH-1:0] res;
      logic             err;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  nRST = 1'b1;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*WIDTH-1:0] req_in1 = '0;
   logic [NREQ*WIDTH-1:0] req_in2 = '0;
   logic [NREQ-1:0]       done;
   logic                  err;
   logic [WIDTH-1:0]      result;
   logic                  busy;
   logic [WIDTH-1:0]      mult_in1, mult_in2;
   logic                  start_mult;
   logic [WIDTH-1:0]      mult_out = '0;
   logic                  mult_finish = 1'b0;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned start_cnt = 0;
   exp_t        sb[$];

   // multiplier model controls
   int unsigned      lat = 3;
   bit               never = 0;
   bit               force_en = 0;
   logic [WIDTH-1:0] force_val = '0;
   bit               inject = 0;
   int unsigned      mcnt = 0;
   logic [WIDTH-1:0] ma, mb;

   mult_arbiter #(
      .NREQ    (NREQ),
      .WIDTH   (WIDTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .nRST        (nRST),
      .req         (req),
      .req_in1     (req_in1),
      .req_in2     (req_in2),
      .done        (done),
      .err         (err),
      .result      (result),
      .busy        (busy),
      .mult_in1    (mult_in1),
      .mult_in2    (mult_in2),
      .start_mult  (start_mult),
      .mult_out    (mult_out),
      .mult_finish (mult_finish)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [31:0] p;
      mult_finish = 1'b0;
      if (!nRST) begin
         mcnt = 0;
      end else begin
         if (inject) begin
            inject      = 0;
            mult_finish = 1'b1;
            mult_out    = 16'd77;
         end
         if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
               p           = ma * mb;
               mult_finish = 1'b1;
               mult_out    = force_en ? force_val : p[WIDTH-1:0];
            end
         end
         if (start_mult) begin
            start_cnt++;
            if (!never) begin
               mcnt = lat;
               ma   = mult_in1;
               mb   = mult_in2;
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (done != '0) begin
         if (sb.size() == 0) begin
            check_val("unexpected_done", 32'(done), 32'd0);
         end else begin
            e = sb.pop_front();
            check_val("done_onehot", 32'(done), 32'd1 << e.idx);
            check_val("result", 32'(result), 32'(e.res));
            check_val("err", 32'(err), 32'(e.err));
         end
      end
   end

   task automatic push_exp(input int unsigned idx, input logic [WIDTH-1:0] res, input logic e);
      exp_t x;
      x.idx = idx;
      x.res = res;
      x.err = e;
      sb.push_back(x);
   endtask

   task automatic set_ops(input int unsigned i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      req_in1[i*WIDTH +: WIDTH] = a;
      req_in2[i*WIDTH +: WIDTH] = b;
   endtask

   task automatic wait_done(input int unsigned idx, input int unsigned maxc, output int unsigned n);
      n = 0;
      while (n < maxc) begin
         @(negedge clk);
         n++;
         if (done[idx]) break;
      end
      if (!done[idx]) check_val("done_timeout", 32'(done), 32'd1 << idx);
   endtask

   task automatic wait_any(input int unsigned maxc, output int unsigned idx);
      int unsigned n;
      n   = 0;
      idx = 0;
      while (n < maxc && done == '0) begin
         @(negedge clk);
         n++;
      end
      if (done == '0) check_val("any_done_timeout", 32'(done), 32'd1);
      for (int unsigned i = 0; i < NREQ; i++) if (done[i]) idx = i;
   endtask

   task automatic do_reset();
      @(negedge clk);
      nRST = 1'b0;
      @(negedge clk);
      nRST = 1'b1;
   endtask

   initial begin
      int unsigned n, k, s0;
      #1 nRST = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst_busy", 32'(busy), 0);
      check_val("rst_done", 32'(done), 0);
      check_val("rst_start", 32'(start_mult), 0);
      check_val("rst_result", 32'(result), 0);
      check_val("rst_in1", 32'(mult_in1), 0);
      nRST = 1'b1;

      // single requester, finish 5 cycles after start
      @(negedge clk);
      lat = 5;
      set_ops(0, 16'd7, 16'd6);
      req = 4'b0001;
      push_exp(0, 16'd42, 1'b0);
      s0 = start_cnt;
      @(negedge clk);
      check_val("start_t1", 32'(start_mult), 1);
      check_val("latched_in1", 32'(mult_in1), 7);
      wait_done(0, 30, n);
      req = '0;
      check_val("done_latency", n, 6);
      check_val("start_pulses", start_cnt - s0, 1);
      @(negedge clk);
      check_val("busy_after", 32'(busy), 0);

      // round robin with all requesters active
      do_reset();
      lat = 3;
      for (int unsigned i = 0; i < NREQ; i++) set_ops(i, WIDTH'(i), 16'd10);
      for (int unsigned i = 0; i < 5; i++) push_exp(i % NREQ, WIDTH'(10 * (i % NREQ)), 1'b0);
      req = 4'b1111;
      for (int unsigned g = 0; g < 5; g++) begin
         wait_any(40, k);
         check_val("rr_order", k, g % NREQ);
         if (g == 4) begin
            req = '0;
         end else begin
            req[k] = 1'b0;
            @(negedge clk);
            req[k] = 1'b1;
         end
      end
      repeat (2) @(negedge clk);

      // timeout with a silent multiplier, then a stale finish in IDLE
      never = 1;
      set_ops(2, 16'd3, 16'd3);
      req = 4'b0100;
      push_exp(2, 16'd0, 1'b1);
      @(negedge clk);
      check_val("to_start", 32'(start_mult), 1);
      wait_done(2, 3 * TIMEOUT, n);
      req = '0;
      check_val("to_latency", n, TIMEOUT + 1);
      never = 0;
      @(negedge clk);
      inject = 1;
      repeat (4) @(negedge clk);
      check_val("stale_busy", 32'(busy), 0);
      check_val("stale_result", 32'(result), 0);

      // finish lands on the timeout cycle
      lat = TIMEOUT;
      force_en = 1;
      force_val = 16'd99;
      set_ops(3, 16'd2, 16'd2);
      req = 4'b1000;
      push_exp(3, 16'd99, 1'b0);
      @(negedge clk);
      wait_done(3, 3 * TIMEOUT, n);
      req = '0;
      force_en = 0;
      check_val("race_latency", n, TIMEOUT + 1);
      @(negedge clk);

      // request dropped and operands changed during WAIT
      lat = 6;
      set_ops(1, 16'd5, 16'd9);
      req = 4'b0010;
      push_exp(1, 16'd45, 1'b0);
      repeat (3) @(negedge clk);
      req = '0;
      set_ops(1, 16'd100, 16'd100);
      check_val("hold_in1", 32'(mult_in1), 5);
      wait_done(1, 30, n);
      @(negedge clk);

      // reset during WAIT aborts silently; grant resumes afterwards
      lat = 10;
      set_ops(1, 16'd3, 16'd4);
      req = 4'b0010;
      repeat (3) @(negedge clk);
      check_val("pre_rst_busy", 32'(busy), 1);
      #2 nRST = 1'b0;
      #1;
      check_val("arst_busy", 32'(busy), 0);
      check_val("arst_result", 32'(result), 0);
      check_val("arst_in1", 32'(mult_in1), 0);
      check_val("arst_done", 32'(done), 0);
      @(negedge clk);
      #2 nRST = 1'b1;
      push_exp(1, 16'd12, 1'b0);
      wait_done(1, 40, n);
      req = '0;
      repeat (3) @(negedge clk);

      check_val("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
